tpx3_rx_arbiter: RTL

- Round-robin arbiter that shares one readout FIFO write port between the NUM_LANES Timepix3 RX lane decoders.
- Sits between the per-lane receive FIFOs (first-word-fall-through, one per DataOut pair) and the common data FIFO feeding the SFP/Ethernet readout.
- Grants bursts of up to MAX_BURST words to eligible lanes and tags each forwarded word with its lane number.
- Gates lanes on software enable and on per-lane RX_READY.

---
 rtl/tpx3_rx_arbiter_pkg.sv | 24 ++
 rtl/tpx3_rx_arbiter_rr_select.sv | 32 +++
 rtl/tpx3_rx_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/tpx3_rx_arbiter_pkg.sv
// Shared definitions for the Timepix3 RX lane arbiter.
//   arb_state_t     : FSM state encoding (IDLE / BURST)
//   DEF_*           : default parameter values for the arbiter top
//   BURST_W         : width of the per-grant word counter (MAX_BURST <= 15)
//   lane_w_for()    : lane index width needed for a given lane count
package tpx3_rx_arbiter_pkg;

  localparam int DEF_NUM_LANES  = 8;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_BURST  = 4;
  localparam int BURST_W        = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  function automatic int lane_w_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_LANE_W = lane_w_for(DEF_NUM_LANES);

endpackage

// File: rtl/tpx3_rx_arbiter_rr_select.sv
// Combinational round-robin picker.
//   elig       : per-lane request mask
//   last_grant : lane granted most recently; it is searched last
//   valid      : at least one lane eligible
//   index      : first eligible lane after last_grant, wrapping
module tpx3_rr_select #(
  parameter int NUM_LANES = 8,
  parameter int LANE_W    = 3
) (
  input  logic [NUM_LANES-1:0] elig,
  input  logic [LANE_W-1:0]    last_grant,
  output logic                 valid,
  output logic [LANE_W-1:0]    index
);

  // Walk the candidates from farthest to nearest so the nearest hit is the
  // last one assigned; avoids a break and keeps the loop purely combinational.
  always_comb begin
    logic [LANE_W-1:0] cand;
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NUM_LANES; k >= 1; k--) begin
      cand = LANE_W'((int'(last_grant) + k) % NUM_LANES);
      if (elig[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/tpx3_rx_arbiter.sv
// Round-robin arbiter sharing one readout FIFO write port between the
// Timepix3 RX lane FIFOs (first-word-fall-through).
//   clk, rst_n    : clock, asynchronous active-low reset
//   lane_enable   : software per-lane enable mask
//   rx_ready      : per-lane decoder-locked flag
//   lane_valid    : lane FIFO not empty
//   lane_data     : lane heads, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   lane_read     : one-hot pop strobe to the lane FIFOs
//   fifo_full     : output FIFO almost-full (>= 2 free entries when set)
//   fifo_write    : write strobe to output FIFO (one cycle after the pop)
//   fifo_data     : forwarded word
//   fifo_lane     : source lane of fifo_data
//   busy          : high while a burst is granted
//   clear_cnt     : synchronous clear of word_cnt (wins over increment)
//   word_cnt      : forwarded-word counter, wraps modulo 2**32
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | arbitration cycle; no pops; grant picks next lane
// ST_BURST | popping cur_lane, up to MAX_BURST words per grant
module tpx3_rx_arbiter
  import tpx3_rx_arbiter_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST,
  parameter int LANE_W     = DEF_LANE_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_LANES-1:0]            lane_enable,
  input  logic [NUM_LANES-1:0]            rx_ready,
  input  logic [NUM_LANES-1:0]            lane_valid,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data,
  output logic [NUM_LANES-1:0]            lane_read,
  input  logic                            fifo_full,
  output logic                            fifo_write,
  output logic [DATA_WIDTH-1:0]           fifo_data,
  output logic [LANE_W-1:0]               fifo_lane,
  output logic                            busy,
  input  logic                            clear_cnt,
  output logic [31:0]                     word_cnt
);

  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST);

  arb_state_t           state, next_state;
  logic [NUM_LANES-1:0] elig;
  logic                 sel_valid;
  logic [LANE_W-1:0]    sel_index;
  logic [LANE_W-1:0]    cur_lane;
  logic [LANE_W-1:0]    last_grant;
  logic [BURST_W-1:0]   burst_cnt;
  logic                 grant;
  logic                 pop;

  assign elig = lane_enable & rx_ready & lane_valid;
  assign busy = (state == ST_BURST);

  tpx3_rr_select #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_rr_select (
    .elig       (elig),
    .last_grant (last_grant),
    .valid      (sel_valid),
    .index      (sel_index)
  );

  // Pop is combinational on elig and fifo_full so a full flag or an enable
  // drop blocks the read in the very cycle it appears.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    pop        = 1'b0;
    lane_read  = '0;
    case (state)
      ST_IDLE: begin
        if (sel_valid && !fifo_full) begin
          grant      = 1'b1;
          next_state = ST_BURST;
        end
      end
      ST_BURST: begin
        pop = elig[cur_lane] && !fifo_full && (burst_cnt < BURST_LAST);
        lane_read[cur_lane] = pop;
        if ((pop && (burst_cnt + 1'b1 == BURST_LAST)) || !elig[cur_lane] || fifo_full)
          next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_lane   <= '0;
      last_grant <= LANE_W'(NUM_LANES - 1);
      burst_cnt  <= '0;
    end else begin
      state <= next_state;
      if (grant) begin
        cur_lane   <= sel_index;
        last_grant <= sel_index;
        burst_cnt  <= '0;
      end else if (pop) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  // Registered write side; reset discards a write still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_write <= 1'b0;
      fifo_data  <= '0;
      fifo_lane  <= '0;
    end else begin
      fifo_write <= pop;
      if (pop) begin
        fifo_data <= lane_data[int'(cur_lane)*DATA_WIDTH +: DATA_WIDTH];
        fifo_lane <= cur_lane;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (clear_cnt) begin
      word_cnt <= '0;
    end else if (fifo_write) begin
      word_cnt <= word_cnt + 32'd1;
    end
  end

endmodule
